// File: rtl/spi_master_tx.sv
// spi_master_tx: SPI master sending one DATA_W-bit word LSB-first per start and returning the received word.
// Ports: clk, rst (sync, active-low), start, CKP, CPH, data_in, MISO -> SS, SCK, MOSI, data_out, busy, done.
// Option: define SPI_MASTER_LOOPBACK_EN to add input loopback (sample MOSI instead of MISO).
module spi_master_tx #(
    parameter int DATA_W   = 16,
    parameter int DIV_HALF = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              CKP,
    input  logic              CPH,
    input  logic [DATA_W-1:0] data_in,
    input  logic              MISO,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic              SS,
    output logic              SCK,
    output logic              MOSI,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DIV_HALF + 1);
    localparam int TOG_W = $clog2(2 * DATA_W + 1);
    localparam int SMP_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [TOG_W-1:0]  tog, tog_n;
    logic [SMP_W-1:0]  smp, smp_n;
    logic [DATA_W-1:0] tx_sr, tx_n;
    logic [DATA_W-1:0] rx_sr, rx_n;
    logic [DATA_W-1:0] dout_n;
    logic              ckp_r, ckp_n;
    logic              cph_r, cph_n;
    logic              ss_n, sck_n, mosi_n, busy_n, done_n;
    logic              div_end, sck_t, sample_edge, rx_bit;

    assign div_end     = (cnt == CNT_W'(DIV_HALF - 1));
    assign sck_t       = ~SCK;
    // A toggle is a sample edge when it rises in CPH=0 or falls in CPH=1
    assign sample_edge = (sck_t != cph_r);
`ifdef SPI_MASTER_LOOPBACK_EN
    assign rx_bit      = loopback ? MOSI : MISO;
`else
    assign rx_bit      = MISO;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tog_n   = tog;
        smp_n   = smp;
        tx_n    = tx_sr;
        rx_n    = rx_sr;
        ckp_n   = ckp_r;
        cph_n   = cph_r;
        ss_n    = SS;
        sck_n   = SCK;
        mosi_n  = MOSI;
        dout_n  = data_out;
        busy_n  = busy;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                sck_n = CKP;
                // done still high means the transfer just ended; that start is dropped
                if (start && !done) begin
                    tx_n    = data_in;
                    rx_n    = '0;
                    ckp_n   = CKP;
                    cph_n   = CPH;
                    ss_n    = 1'b0;
                    mosi_n  = data_in[0];
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    tog_n   = '0;
                    smp_n   = '0;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (div_end) begin
                    cnt_n   = '0;
                    state_n = SHIFT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (div_end) begin
                    cnt_n = '0;
                    sck_n = sck_t;
                    tog_n = tog + 1'b1;
                    if (sample_edge) begin
                        rx_n  = {rx_bit, rx_sr[DATA_W-1:1]};
                        smp_n = smp + 1'b1;
                    end else if (smp != '0 && smp < SMP_W'(DATA_W)) begin
                        // A leading shift edge keeps bit 0 on the line
                        mosi_n = tx_sr[1];
                        tx_n   = tx_sr >> 1;
                    end
                    if (tog == TOG_W'(2 * DATA_W - 1)) begin
                        state_n = HOLD;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HOLD: begin
                sck_n = ckp_r;
                if (div_end) begin
                    cnt_n   = '0;
                    ss_n    = 1'b1;
                    dout_n  = rx_sr;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            tog      <= '0;
            smp      <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            ckp_r    <= 1'b0;
            cph_r    <= 1'b0;
            SS       <= 1'b1;
            SCK      <= 1'b0;
            MOSI     <= 1'b0;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            tog      <= tog_n;
            smp      <= smp_n;
            tx_sr    <= tx_n;
            rx_sr    <= rx_n;
            ckp_r    <= ckp_n;
            cph_r    <= cph_n;
            SS       <= ss_n;
            SCK      <= sck_n;
            MOSI     <= mosi_n;
            data_out <= dout_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: scoreboard bench for spi_master_tx with a bit-level SPI slave model.
// Expected words are queued at start; a negedge monitor checks MOSI per sample edge and data_out at done.
module tb_spi_master_tx;

    localparam int DW = 16;
    localparam int DH = 2;
    localparam int LOW_CYC  = (2 * DW + 2) * DH;
    localparam int DONE_LAT = LOW_CYC + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          CKP = 1'b0;
    logic          CPH = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          MISO = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic          loopback = 1'b0;
`endif
    logic          SS, SCK, MOSI, busy, done;
    logic [DW-1:0] data_out;

    spi_master_tx #(.DATA_W(DW), .DIV_HALF(DH)) dut (
        .clk(clk), .rst(rst), .start(start), .CKP(CKP), .CPH(CPH),
        .data_in(data_in), .MISO(MISO),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback(loopback),
`endif
        .SS(SS), .SCK(SCK), .MOSI(MOSI), .data_out(data_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] tx;
        logic [DW-1:0] slave;
        logic [DW-1:0] rx;
        int            start_cyc;
        logic          ckp;
        logic          cph;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    int   k = 0;
    int   lowcnt = 0;
    logic prev_sck = 1'b0;
    logic prev_mosi = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor and slave model: the slave presents bit k of its word until the k-th sample edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst && done === 1'b1) begin
            done_cnt++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no transfer (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("data_out", 32'(data_out), 32'(e.rx));
                chk("done_cycle", cyc, e.start_cyc + DONE_LAT);
                chk("sample_edges", k, DW);
                chk("ss_low_cycles", lowcnt, LOW_CYC);
                chk("sck_idle_at_done", 32'(SCK), 32'(e.ckp));
                chk("busy_at_done", 32'(busy), 0);
            end
        end
        if (SS === 1'b0) begin
            lowcnt++;
            if (SCK !== prev_sck && q.size() != 0) begin
                if (SCK == ~q[0].cph) begin
                    if (k < DW)
                        chk($sformatf("mosi_bit%0d", k), 32'({prev_mosi, MOSI}),
                            32'({2{q[0].tx[k]}}));
                    k++;
                end
            end
        end else begin
            lowcnt = 0;
            k = 0;
        end
        prev_sck  = SCK;
        prev_mosi = MOSI;
        MISO = (q.size() != 0 && k < DW) ? q[0].slave[k] : 1'b0;
    end

    task automatic do_start(input logic [DW-1:0] w, input logic [DW-1:0] s,
                            input logic [DW-1:0] rx, input logic ckp, input logic cph);
        exp_t e;
        @(negedge clk);
        CKP = ckp;
        CPH = cph;
        data_in = w;
        @(negedge clk);
        start = 1'b1;
        e.tx = w;
        e.slave = s;
        e.rx = rx;
        e.start_cyc = cyc;
        e.ckp = ckp;
        e.cph = cph;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 200);
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
    endtask

    initial begin
        logic [DW-1:0] w, s;
        int saved;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ss", 32'(SS), 1);
        chk("reset_sck", 32'(SCK), 0);
        chk("reset_mosi", 32'(MOSI), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_data_out", 32'(data_out), 0);
        rst = 1'b1;

        do_start(16'hA5C3, 16'h3C5A, 16'h3C5A, 1'b0, 1'b0);
        wait_done();

        for (int m = 1; m < 4; m++) begin
            logic [1:0] mb;
            mb = 2'(m);
            do_start(16'h8001, 16'hFFFF, 16'hFFFF, mb[1], mb[0]);
            wait_done();
        end

        w = 16'($urandom);
        s = 16'($urandom);
        do_start(w, s, s, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        start = 1'b1;
        data_in = 16'h1234;
        CKP = 1'b1;
        CPH = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        start = 1'b1;
        data_in = 16'h0F0F;
        @(negedge clk);
        start = 1'b0;
        chk("start_on_done_busy", 32'(busy), 0);
        chk("start_on_done_ss", 32'(SS), 1);
        do_start(16'h1234, 16'h4321, 16'h4321, 1'b1, 1'b0);
        wait_done();

        do_start(16'hFFFF, 16'h5555, 16'h5555, 1'b0, 1'b0);
        repeat (29) @(negedge clk);
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("abort_ss", 32'(SS), 1);
        chk("abort_sck", 32'(SCK), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        rst = 1'b1;
        saved = done_cnt;
        repeat (80) @(negedge clk);
        chk("abort_no_done", done_cnt, saved);

        for (int i = 0; i < 6; i++) begin
            logic [1:0] md;
            w = 16'($urandom);
            s = 16'($urandom);
            md = 2'($urandom_range(0, 3));
            do_start(w, s, s, md[1], md[0]);
            repeat ($urandom_range(2, 40)) @(negedge clk);
            CKP = ~md[1];
            CPH = ~md[0];
            wait_done();
        end

`ifdef SPI_MASTER_LOOPBACK_EN
        loopback = 1'b1;
        do_start(16'hDEAD, 16'h0000, 16'hDEAD, 1'b0, 1'b0);
        wait_done();
        loopback = 1'b0;
`endif

        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
